// File: rtl/serial_magnitude_restore.sv
// Bit-serial two's-complement to sign-magnitude converter.
// LSB-first "copy up to first 1, then invert", one bit per clock.
module serial_magnitude_restore #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_sign,
   output logic             out_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             seen_q, seen_d;
   logic             sign_q, sign_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             osign_q, osign_d;
   logic             zero_q, zero_d;

   logic             b;
   logic             r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         osign_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         osign_q <= osign_d;
         zero_q  <= zero_d;
      end
   end

   // Bits above the first 1 are inverted only for negative operands.
   assign b = work_q[0];
   assign r = (sign_q && seen_q) ? ~b : b;

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      seen_d    = seen_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      osign_d   = osign_q;
      zero_d    = zero_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d  = in_data;
               sign_d  = in_data[WIDTH-1];
               res_d   = '0;
               cnt_d   = '0;
               seen_d  = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = work_q >> 1;
            res_d  = {r, res_q[WIDTH-1:1]};
            seen_d = seen_q | b;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               mag_d   = res_d;
               osign_d = sign_q;
               zero_d  = !sign_q && !(seen_q | b);
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out_mag  = mag_q;
   assign out_sign = osign_q;
   assign out_zero = zero_q;

endmodule

// File: tb/tb_serial_magnitude_restore.sv
// Directed and random bench for serial_magnitude_restore, WIDTH=24 and WIDTH=8.
module tb_serial_magnitude_restore;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [23:0] in_data, out_mag;
   logic        out_sign, out_zero;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  in_data8, out_mag8;
   logic        out_sign8, out_zero8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_magnitude_restore #(.WIDTH(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mag(out_mag), .out_sign(out_sign), .out_zero(out_zero)
   );

   serial_magnitude_restore #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_mag(out_mag8), .out_sign(out_sign8), .out_zero(out_zero8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: magnitude by plain arithmetic negation within w bits.
   function automatic logic [23:0] ref_mag(input logic [23:0] x, input int w);
      logic [23:0] mask;
      mask = (24'h1 << w) - 24'h1;
      if (x[w-1]) return (24'h0 - x) & mask;
      return x & mask;
   endfunction

   task automatic op24(input logic [23:0] d, input int hold);
      logic [23:0] em;
      logic es, ez;
      int lat;
      em = ref_mag(d, 24);
      es = d[23];
      ez = (d == 24'h0);
      out_ready = 1'b0;
      @(negedge clk);
      check("in_ready_before", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         in_data = $urandom;
         lat++;
      end
      check("latency", lat, 24);
      check("mag", out_mag, em);
      check("sign", out_sign, es);
      check("zero", out_zero, ez);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_mag", out_mag, em);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_mag_kept", out_mag, em);
   endtask

   logic [7:0] vec8 [3];
   logic       acc;
   logic       saw_valid;
   int         k, n, lastacc, lastout;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_mag", out_mag, 0);
      check("rst_sign", out_sign, 0);
      check("rst_zero", out_zero, 0);
      check("rst8_in_ready", in_ready8, 1);
      @(negedge clk);
      rst = 1'b0;

      op24(24'hFFFFFF, 0);
      op24(24'h800000, 0);
      op24(24'h123456, 0);
      op24(24'h000000, 0);
      op24(24'hFFFF00, 5);
      op24(24'h7FFFFF, 1);

      // Abort mid-operation
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 24'h123456;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("abort_no_result", saw_valid, 0);
      op24(24'hFFFFFE, 0);

      for (int i = 0; i < 16; i++) begin
         op24(24'($urandom), int'($urandom_range(0, 2)));
      end

      // WIDTH=8 back-to-back stream
      vec8[0] = 8'h80; vec8[1] = 8'h7F; vec8[2] = 8'h01;
      k = 0; n = 0; lastacc = -1; lastout = -1;
      for (int c = 0; c < 60; c++) begin
         in_valid8 = (k < 3);
         in_data8  = (k < 3) ? vec8[k] : 8'($urandom);
         acc = in_valid8 && in_ready8;
         @(negedge clk);
         if (acc) begin
            if (k > 0) check("w8_accept_gap", c - lastacc, 10);
            lastacc = c;
            k++;
         end
         if (out_valid8) begin
            if (n < 3) begin
               check("w8_mag", out_mag8, ref_mag({16'h0, vec8[n]}, 8));
               check("w8_sign", out_sign8, vec8[n][7]);
               check("w8_zero", out_zero8, 0);
            end
            if (n > 0) check("w8_out_gap", c - lastout, 10);
            lastout = c;
            n++;
         end
      end
      check("w8_accepts", k, 3);
      check("w8_results", n, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
